// File: rtl/load_store_unit.sv
// Handshaked load/store unit: one request at a time, alignment/size checks, big-endian
// byte-lane packing onto a variable-latency memory port with an acknowledge timeout.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT > 0) ? CNTW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_SIZE  = 2'b11;

  logic [1:0]      r_state;
  logic            r_is_store;
  logic            r_unsigned;
  logic [1:0]      r_size;
  logic [OFFW-1:0] r_off;
  logic [CNTW-1:0] r_cnt;
  logic            r_mem_req;
  logic [XLEN-1:0] r_mem_addr;
  logic [NB-1:0]   r_mem_we;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic [1:0]      r_resp_err;

  logic [OFFW-1:0] w_off;
  logic [OFFW-1:0] w_align_mask;
  logic            w_size_ok;
  logic            w_aligned;
  logic [NB-1:0]   w_pack_we;
  logic [XLEN-1:0] w_pack_wdata;
  logic [XLEN-1:0] w_ld_raw;
  logic [XLEN-1:0] w_ld_mask;
  logic [XLEN-1:0] w_ld_ext;
  logic            w_sign;
  logic            w_timeout;

  assign w_off        = req_addr[OFFW-1:0];
  assign w_size_ok    = (req_size != 2'd3) || (XLEN == 64);
  assign w_align_mask = OFFW'((1 << req_size) - 1);
  assign w_aligned    = (w_off & w_align_mask) == '0;
  assign w_timeout    = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  // Store packing: lane off+i carries byte (n-1-i) of the right-justified data, MSB first.
  always_comb begin
    w_pack_we    = '0;
    w_pack_wdata = '0;
    if (req_is_store && w_size_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (k >= int'(w_off) && k < int'(w_off) + (1 << req_size)) begin
          w_pack_we[k] = 1'b1;
          w_pack_wdata[XLEN-1-8*k -: 8] =
            req_wdata[8*(int'(w_off) + (1 << req_size) - 1 - k) +: 8];
        end
      end
    end
  end

  // Load extraction: lane off becomes the most significant byte of the result.
  always_comb begin
    w_ld_raw  = '0;
    w_ld_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << r_size) && int'(r_off) + i < NB) begin
        w_ld_raw[8*((1 << r_size) - 1 - i) +: 8] = mem_rdata[XLEN-1-8*(int'(r_off) + i) -: 8];
        w_ld_mask[8*i +: 8] = 8'hFF;
      end
    end
  end

  assign w_sign   = ~r_unsigned & mem_rdata[XLEN-1-8*int'(r_off)];
  assign w_ld_ext = w_ld_raw | ({XLEN{w_sign}} & ~w_ld_mask);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'd0;
      r_off        <= '0;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_is_store   <= req_is_store;
            r_unsigned   <= req_unsigned;
            r_size       <= req_size;
            r_off        <= w_off;
            r_cnt        <= '0;
            r_resp_rdata <= '0;
            if (!w_size_ok) begin
              r_resp_err   <= ERR_SIZE;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (!w_aligned) begin
              r_resp_err   <= ERR_ALIGN;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              r_mem_we    <= w_pack_we;
              r_mem_wdata <= w_pack_wdata;
              r_state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= '0;
            r_resp_err   <= ERR_OK;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
            if (!r_is_store) begin
              r_resp_rdata <= w_ld_ext;
            end
          end else if (w_timeout) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= '0;
            r_resp_err   <= ERR_TMO;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit (XLEN=32, TIMEOUT=4) against a
// byte-addressed memory model with big-endian multi-byte accesses.
module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic        clk;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_b [0:1023];

  load_store_unit #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int base);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = mem_b[base+k];
    return w;
  endfunction

  // One full transaction, starting and ending at a negedge with the unit idle.
  task automatic do_req(input logic st, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input int hold,
                        output logic [31:0] got_rd, output logic [1:0] got_err,
                        output logic [3:0] got_we, output logic [31:0] got_wd);
    int n, off, base, ncyc, e_cyc;
    logic [1:0]  e_err;
    logic [3:0]  e_we;
    logic [31:0] e_wd, e_rd;
    longint      v;
    n = 1 << size;
    off = int'(addr[1:0]);
    base = int'(addr[9:0]) - off;
    if (size == 2'd3) e_err = 2'b11;
    else if (off % n != 0) e_err = 2'b01;
    else e_err = 2'b00;
    e_we = '0;
    e_wd = '0;
    if (st && e_err == 2'b00) begin
      for (int i = 0; i < n; i++) begin
        e_we[off+i] = 1'b1;
        e_wd = e_wd | (((wdata >> (8*(n-1-i))) & 32'hFF) << (8*(3-(off+i))));
      end
    end
    got_we = '0;
    got_wd = '0;

    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_is_store = st; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // Scramble the request fields to prove the unit latched them.
    req_valid = 1'b0; req_is_store = $urandom; req_size = 2'($urandom);
    req_unsigned = $urandom; req_addr = $urandom; req_wdata = $urandom;

    ncyc = 0;
    while (mem_req === 1'b1 && ncyc < 20) begin
      ncyc++;
      if (ncyc == 1) begin
        got_we = mem_we;
        got_wd = mem_wdata;
      end
      check("mem_addr", 64'(mem_addr), 64'(addr & 32'hFFFF_FFFC));
      check("mem_we", 64'(mem_we), 64'(e_we));
      check("mem_wdata", 64'(mem_wdata), 64'(e_wd));
      if (ncyc == delay + 1) begin
        mem_ack = 1'b1;
        mem_rdata = model_word(base);
        if (st) for (int i = 0; i < n; i++) mem_b[int'(addr[9:0])+i] = wdata[8*(n-1-i) +: 8];
      end else begin
        mem_rdata = $urandom;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end

    if (e_err != 2'b00) e_cyc = 0;
    else if (delay < TMO) e_cyc = delay + 1;
    else begin
      e_cyc = TMO;
      e_err = 2'b10;
    end
    check("mem_req_cycles", 64'(ncyc), 64'(e_cyc));

    e_rd = '0;
    if (!st && e_err == 2'b00) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | longint'(mem_b[int'(addr[9:0])+i]);
      if (!uns && v[8*n-1]) v = v - (longint'(1) << (8*n));
      e_rd = v[31:0];
    end

    check("resp_valid", 64'(resp_valid), 64'd1);
    check("resp_err", 64'(resp_err), 64'(e_err));
    check("resp_rdata", 64'(resp_rdata), 64'(e_rd));
    check("req_ready_resp", 64'(req_ready), 64'd0);
    got_rd = resp_rdata;
    got_err = resp_err;

    resp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_addr = $urandom;
      mem_ack = $urandom;
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", 64'(resp_rdata), 64'(e_rd));
      check("hold_err", 64'(resp_err), 64'(e_err));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_mem_req", 64'(mem_req), 64'd0);
    end
    resp_ready = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_resp_valid", 64'(resp_valid), 64'd0);
    check("post_req_ready", 64'(req_ready), 64'd1);
    check("post_mem_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    logic [31:0] rd, wd;
    logic [1:0]  er;
    logic [3:0]  we;
    logic [1:0]  sz;
    logic [31:0] ad;

    for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
    rst_b = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_ack = 1'b0;
    mem_rdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, rd, er, we, wd);
    check("word_store_we", 64'(we), 64'hF);
    check("word_store_wdata", 64'(wd), 64'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 0, rd, er, we, wd);
    check("word_load_data", 64'(rd), 64'hDEADBEEF);
    check("word_load_err", 64'(er), 64'd0);

    mem_b[32'h100] = 8'h00; mem_b[32'h101] = 8'h00;
    mem_b[32'h102] = 8'h00; mem_b[32'h103] = 8'hF0;
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 0, rd, er, we, wd);
    check("byte_load_signed", 64'(rd), 64'hFFFFFFF0);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, rd, er, we, wd);
    check("byte_load_unsigned", 64'(rd), 64'h000000F0);

    // Half store at offset 2 occupies lanes 2 and 3, i.e. mem_we bits 2 and 3.
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 2, 0, rd, er, we, wd);
    check("half_store_we", 64'(we), 64'hC);
    check("half_store_wdata", 64'(wd), 64'h0000ABCD);
    do_req(1'b0, 2'd1, 1'b0, 32'h201, 32'h0, 0, 0, rd, er, we, wd);
    check("misaligned_err", 64'(er), 64'd1);

    do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 99, 0, rd, er, we, wd);
    check("timeout_err", 64'(er), 64'd2);
    check("timeout_rdata", 64'(rd), 64'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'h308, 32'h0, 0, 0, rd, er, we, wd);
    check("dword_illegal_err", 64'(er), 64'd3);
    do_req(1'b1, 2'd3, 1'b0, 32'h301, 32'h55, 0, 0, rd, er, we, wd);
    check("size_over_align_err", 64'(er), 64'd3);

    do_req(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 1, 5, rd, er, we, wd);
    check("backpressure_data", 64'(rd), 64'h0000ABCD);

    // Reset in the middle of an access.
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_mem_req_before", 64'(mem_req), 64'd1);
    rst_b = 1'b0;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_resp", 64'(resp_valid), 64'd0);
    end
    mem_ack = 1'b0;
    do_req(1'b0, 2'd2, 1'b1, 32'h200, 32'h0, 2, 0, rd, er, we, wd);
    check("midrst_next_err", 64'(er), 64'd0);

    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom,
             int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), rd, er, we, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
